// File: rtl/histogram_edge_scanner.sv
// Acquires a histogram through the recorder CSR, scans one channel's bins for the first
// rising edge and optionally commits that bin as coincidence point and requests realignment.
module histogram_edge_scanner #(
    parameter int CHANNEL_COUNT        = 2,
    parameter int SAMPLE_COUNTER_WIDTH = 8,
    parameter int SUM_WIDTH            = 12,
    parameter int TIMEOUT_CYCLES       = 1000000,
    localparam int MUXSEL_WIDTH        = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                            sysClk,
    input  logic                            sysReset,
    input  logic                            start,
    input  logic [MUXSEL_WIDTH-1:0]         channel,
    input  logic [SUM_WIDTH-1:0]            threshold,
    input  logic                            autoCommit,
    output logic                            csrStrobe,
    output logic [31:0]                     csrGPIO_OUT,
    input  logic [31:0]                     csrStatus,
    output logic                            busy,
    output logic                            done,
    output logic                            edgeFound,
    output logic [SAMPLE_COUNTER_WIDTH-1:0] edgeAddress,
    output logic                            timeoutError
);

    localparam int SCW   = SAMPLE_COUNTER_WIDTH;
    localparam int SW    = SUM_WIDTH;
    localparam int MW    = MUXSEL_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0]      CMD_KICK    = 32'h8000_0000;
    localparam logic [31:0]      CMD_COMMIT  = 32'h4000_0000;
    localparam logic [31:0]      CMD_REALIGN = 32'h2000_0000;
    localparam logic [SCW-1:0]   LAST_BIN    = {SCW{1'b1}};
    localparam logic [SCW-1:0]   FIRST_BIN   = {SCW{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ZERO    = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_KICK          = 4'd1,
        ST_WAIT_BUSY_SET = 4'd2,
        ST_WAIT_BUSY_CLR = 4'd3,
        ST_SET_ADDR      = 4'd4,
        ST_WAIT_RB       = 4'd5,
        ST_EVAL          = 4'd6,
        ST_COMMIT        = 4'd7,
        ST_REALIGN       = 4'd8,
        ST_FINISH        = 4'd9
    } state_t;

    function automatic logic [31:0] addr_cmd(input logic [MW-1:0] ch, input logic [SCW-1:0] bin);
        logic [31:0] w;
        w           = 32'h0000_0000;
        w[24 +: MW] = ch;
        w[0 +: SCW] = bin;
        return w;
    endfunction

    function automatic logic [31:0] commit_cmd(input logic [SCW-1:0] bin);
        logic [31:0] w;
        w           = CMD_COMMIT;
        w[0 +: SCW] = bin;
        return w;
    endfunction

    state_t           state_q, state_d;
    logic [MW-1:0]    channel_q, channel_d;
    logic [SW-1:0]    threshold_q, threshold_d;
    logic             auto_q, auto_d;
    logic [SCW-1:0]   k_q, k_d;
    logic [SW-1:0]    value_q, value_d;
    logic             high0_q, high0_d;
    logic             prev_q, prev_d;
    logic             realign_arm_q, realign_arm_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             strobe_q, strobe_d;
    logic [31:0]      gpio_q, gpio_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             edge_q, edge_d;
    logic [SCW-1:0]   edge_addr_q, edge_addr_d;
    logic             tmo_err_q, tmo_err_d;

    logic             st_busy_s;
    logic [MW-1:0]    st_mux_s;
    logic [SCW-1:0]   st_addr_s;
    logic [SW-1:0]    st_val_s;
    logic             unused_status_s;
    logic             high_s, last_s, rise_s, wrap_s, found_s, tmo_hit_s, rb_match_s;
    logic [SCW-1:0]   commit_addr_s;

    assign st_busy_s       = csrStatus[31];
    assign st_mux_s        = csrStatus[24 +: MW];
    assign st_addr_s       = csrStatus[SW +: SCW];
    assign st_val_s        = csrStatus[0 +: SW];
    assign unused_status_s = ^csrStatus;

    assign high_s    = (value_q >= threshold_q);
    assign last_s    = (k_q == LAST_BIN);
    assign rise_s    = (k_q != FIRST_BIN) && !prev_q && high_s && !edge_q;
    // Bin 0 only counts as the edge when nothing in 1..last rose and the histogram wraps low->high.
    assign wrap_s    = last_s && !edge_q && !rise_s && !high_s && high0_q;
    assign found_s   = edge_q || rise_s || wrap_s;
    assign commit_addr_s = rise_s ? k_q : (wrap_s ? FIRST_BIN : edge_addr_q);
    assign tmo_hit_s = (tmo_q == TMO_LAST);
    // The first cycle of WAIT_RB is skipped so a match left over from an older read is never taken.
    assign rb_match_s = (tmo_q != TMO_ZERO) && (st_addr_s == k_q) && (st_mux_s == channel_q);

    // Next-state, CSR command and result computation.
    always_comb begin
        state_d       = state_q;
        channel_d     = channel_q;
        threshold_d   = threshold_q;
        auto_d        = auto_q;
        k_d           = k_q;
        value_d       = value_q;
        high0_d       = high0_q;
        prev_d        = prev_q;
        realign_arm_d = 1'b0;
        tmo_d         = tmo_q;
        strobe_d      = 1'b0;
        gpio_d        = gpio_q;
        edge_d        = edge_q;
        edge_addr_d   = edge_addr_q;
        tmo_err_d     = tmo_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    channel_d   = channel;
                    threshold_d = threshold;
                    auto_d      = autoCommit;
                    edge_d      = 1'b0;
                    edge_addr_d = FIRST_BIN;
                    tmo_err_d   = 1'b0;
                    strobe_d    = 1'b1;
                    gpio_d      = CMD_KICK;
                    state_d     = ST_KICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KICK: begin
                tmo_d   = TMO_ZERO;
                state_d = ST_WAIT_BUSY_SET;
            end
            ST_WAIT_BUSY_SET: begin
                if (st_busy_s) begin
                    tmo_d   = TMO_ZERO;
                    state_d = ST_WAIT_BUSY_CLR;
                end else if (tmo_hit_s) begin
                    tmo_err_d = 1'b1;
                    edge_d    = 1'b0;
                    state_d   = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_BUSY_CLR: begin
                if (!st_busy_s) begin
                    k_d      = FIRST_BIN;
                    strobe_d = 1'b1;
                    gpio_d   = addr_cmd(channel_q, FIRST_BIN);
                    state_d  = ST_SET_ADDR;
                end else if (tmo_hit_s) begin
                    tmo_err_d = 1'b1;
                    edge_d    = 1'b0;
                    state_d   = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SET_ADDR: begin
                tmo_d   = TMO_ZERO;
                state_d = ST_WAIT_RB;
            end
            ST_WAIT_RB: begin
                if (rb_match_s) begin
                    value_d = st_val_s;
                    state_d = ST_EVAL;
                end else if (tmo_hit_s) begin
                    tmo_err_d = 1'b1;
                    edge_d    = 1'b0;
                    state_d   = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_EVAL: begin
                prev_d = high_s;
                if (k_q == FIRST_BIN) begin
                    high0_d = high_s;
                end else begin
                    high0_d = high0_q;
                end
                if (rise_s || wrap_s) begin
                    edge_d      = 1'b1;
                    edge_addr_d = commit_addr_s;
                end else begin
                    edge_d = edge_q;
                end
                if (!last_s) begin
                    k_d      = k_q + 1'b1;
                    strobe_d = 1'b1;
                    gpio_d   = addr_cmd(channel_q, k_q + 1'b1);
                    state_d  = ST_SET_ADDR;
                end else if (found_s && auto_q) begin
                    strobe_d = 1'b1;
                    gpio_d   = commit_cmd(commit_addr_s);
                    state_d  = ST_COMMIT;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_COMMIT: begin
                state_d = ST_REALIGN;
            end
            // First REALIGN cycle is a gap so the commit and realign strobes never touch.
            ST_REALIGN: begin
                if (!realign_arm_q) begin
                    realign_arm_d = 1'b1;
                    strobe_d      = 1'b1;
                    gpio_d        = CMD_REALIGN;
                    state_d       = ST_REALIGN;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d = (state_d == ST_FINISH);
    end

    // State and registered outputs; reset drops everything, including any pending strobe.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q       <= ST_IDLE;
            channel_q     <= {MW{1'b0}};
            threshold_q   <= {SW{1'b0}};
            auto_q        <= 1'b0;
            k_q           <= FIRST_BIN;
            value_q       <= {SW{1'b0}};
            high0_q       <= 1'b0;
            prev_q        <= 1'b0;
            realign_arm_q <= 1'b0;
            tmo_q         <= TMO_ZERO;
            strobe_q      <= 1'b0;
            gpio_q        <= 32'h0000_0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            edge_q        <= 1'b0;
            edge_addr_q   <= FIRST_BIN;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            channel_q     <= channel_d;
            threshold_q   <= threshold_d;
            auto_q        <= auto_d;
            k_q           <= k_d;
            value_q       <= value_d;
            high0_q       <= high0_d;
            prev_q        <= prev_d;
            realign_arm_q <= realign_arm_d;
            tmo_q         <= tmo_d;
            strobe_q      <= strobe_d;
            gpio_q        <= gpio_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            edge_q        <= edge_d;
            edge_addr_q   <= edge_addr_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign csrStrobe    = strobe_q;
    assign csrGPIO_OUT  = gpio_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign edgeFound    = edge_q;
    assign edgeAddress  = edge_addr_q;
    assign timeoutError = tmo_err_q;

endmodule

// File: doc/histogram_edge_scanner.md
# histogram_edge_scanner

Sequencer in the system clock domain that drives the coincidence recorder's CSR as if it were software. It starts a histogram acquisition, waits for completion, and reads back every bin of one selected channel. It then locates the first rising edge of that channel's histogram and, optionally, programs that bin as the coincidence point and requests a heartbeat realignment. It sits directly upstream of the recorder's CSR port (strobe/GPIO_OUT in, status word out), which frees firmware from the per-bin polling loop.

## Interface
- CHANNEL_COUNT, 2: recorder channel count; MUXSEL_WIDTH = $clog2(CHANNEL_COUNT), minimum 1.
- SAMPLE_COUNTER_WIDTH, 8: histogram address width; bins = 2**SAMPLE_COUNTER_WIDTH.
- SUM_WIDTH, 12: width of one histogram bin value.
- TIMEOUT_CYCLES, 1000000: maximum sysClk cycles spent in any single wait state.
- sysClk  in  1  system clock; sole clock.
- sysReset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; ignored unless idle.
- channel  in  MUXSEL_WIDTH  channel to scan; captured on accepted start.
- threshold  in  SUM_WIDTH  level a bin must reach to count as "high"; captured on start.
- autoCommit  in  1  captured on start; 1 = program coincidence and realign after a found edge.
- csrStrobe  out  1  one-cycle write strobe to recorder.
- csrGPIO_OUT  out  32  write data; valid in the strobe cycle and held until the next strobe.
- csrStatus  in  32  recorder status: [31] busy, [24+:MUXSEL_WIDTH] readback mux, [SUM_WIDTH+:SAMPLE_COUNTER_WIDTH] readback address, [0+:SUM_WIDTH] bin value.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end, success or error.
- edgeFound  out  1  last scan found a rising edge.
- edgeAddress  out  SAMPLE_COUNTER_WIDTH  bin index of that edge.
- timeoutError  out  1  last scan aborted by timeout.

## Operation
- States: IDLE, KICK, WAIT_BUSY_SET, WAIT_BUSY_CLR, SET_ADDR, WAIT_RB, EVAL, COMMIT, REALIGN, FINISH.
- IDLE: if start, capture channel/threshold/autoCommit, clear edgeFound/timeoutError/edgeAddress, go to KICK; busy=1 from the next cycle.
- KICK: strobe with GPIO_OUT = 0x80000000 (start acquisition); go to WAIT_BUSY_SET.
- WAIT_BUSY_SET: wait for csrStatus[31]=1, then go to WAIT_BUSY_CLR.
- WAIT_BUSY_CLR: wait for csrStatus[31]=0; bin index k=0; go to SET_ADDR.
- SET_ADDR: strobe with bits[31:29]=0, [24+:MUXSEL_WIDTH]=channel, [0+:SAMPLE_COUNTER_WIDTH]=k, all other bits 0; go to WAIT_RB.
- WAIT_RB: readback is valid when the status address equals k and the status mux equals channel in the same cycle. Register the value, go to EVAL. The match must be evaluated no earlier than 2 cycles after the strobe, so a stale match from an earlier identical address is never accepted.
- EVAL: high = (value >= threshold), unsigned. For k=0, store high0 and prevHigh=high. For k>0, if !prevHigh && high && !edgeFound, set edgeFound=1 and edgeAddress=k. Then set prevHigh=high. If k < last, increment k and go to SET_ADDR.
- After the last bin: wrap check; if !edgeFound && !prevHigh && high0, set edgeFound=1 and edgeAddress=0. Then go to COMMIT if edgeFound && autoCommit, else FINISH.
- The first edge in order 1..last wins, then bin 0 via the wrap check. An all-high or all-low histogram gives edgeFound=0.
- COMMIT: strobe with GPIO_OUT = 0x40000000 | edgeAddress; go to REALIGN.
- REALIGN: strobe with GPIO_OUT = 0x20000000; go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. Result outputs hold until the next accepted start.
- Timeout: a counter is cleared on entry to each WAIT_* state. If it reaches TIMEOUT_CYCLES, set timeoutError=1, edgeFound=0, skip COMMIT/REALIGN, go to FINISH.
- Reset, mid-scan or otherwise: immediately return to IDLE. All outputs go to 0, including csrGPIO_OUT=0 and csrStrobe=0. No further strobes are issued.

## Timing
- Every strobe is exactly one cycle. Strobes are separated by at least one non-strobe cycle. start during busy has no effect.
- Latency from start to the KICK strobe: 1 cycle (start in cycle n, strobe in cycle n+1).
- Per-bin cost: 1 (SET_ADDR) + recorder round trip + 1 (WAIT_RB capture) + 1 (EVAL).
- done occurs one cycle after the last EVAL, or one cycle after REALIGN when committing.
- A timeout is flagged after exactly TIMEOUT_CYCLES cycles in the wait state.

## Test plan
- Recorder model with 6-cycle readback, 256 bins, bins 0..99 = 0 and 100..255 = 4095, threshold 2048, autoCommit=1 -> edgeAddress=100 and edgeFound=1; strobe sequence 0x80000000, then 256 address writes, then 0x40000064, then 0x20000000; one done pulse.
- Bins 0..9 high, 10..249 low, 250..255 high -> edgeAddress=250. Bins 0..9 high, rest low -> edgeAddress=0 via wrap.
- All bins 4095, autoCommit=1 -> edgeFound=0, no 0x4/0x2 strobes, done pulses.
- Model never asserts busy, TIMEOUT_CYCLES=50 -> timeoutError=1 and done exactly 50 cycles after entering WAIT_BUSY_SET.
- Model returns a stale address (k-1) for 3 cycles before the correct one -> the stale value is never used, verified by distinct bin values.
- Assert sysReset during bin 37 -> next cycle busy=0, csrStrobe=0, csrGPIO_OUT=0; a new start then runs a clean full scan.
